pe_mac_cell: RTL

//  Parametrised systolic-array processing element; successor to the basic PE MAC.

---
 rtl/pe_mac_cell.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/pe_mac_cell.sv
// -----------------------------------------------------------------------------
// pe_mac_cell
//   Systolic-array processing element. Operands arriving from above and from the
//   left are forwarded down/right one cycle later, unconditionally. When both
//   operands are valid on the same cycle (a MAC beat) their product is formed in
//   stage 1 and accumulated in stage 2 into an ACC_WIDTH accumulator, signed or
//   unsigned per beat. The last beat of a tile loads a tagged result register
//   that is offered over a valid/ready handshake.
//
// Parameters
//   DATA_WIDTH  operand width
//   ACC_WIDTH   accumulator / result width (>= 2*DATA_WIDTH)
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   up_i / up_valid_i            top operand and its valid
//   left_i / left_valid_i        left operand and its valid
//   first_i, last_i, signed_i    left-channel tile tags (used on MAC beats only)
//   down_o / down_valid_o        up operand delayed one cycle
//   right_o / right_*_o          left operand and tags delayed one cycle
//   res_o, res_ovf_o             tile result and its overflow flag
//   res_valid_o / res_ready_i    result handshake (valid held until accepted)
//   res_lost_o                   sticky: an unaccepted result was overwritten
//
// Configuration
//   PE_MAC_SATURATE_EN  when defined, stage-2 overflow clamps the accumulator to
//                       the extreme of the beat's mode instead of wrapping.
// -----------------------------------------------------------------------------
module pe_mac_cell #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] up_i,
    input  logic                  up_valid_i,
    input  logic [DATA_WIDTH-1:0] left_i,
    input  logic                  left_valid_i,
    input  logic                  first_i,
    input  logic                  last_i,
    input  logic                  signed_i,
    output logic [DATA_WIDTH-1:0] down_o,
    output logic                  down_valid_o,
    output logic [DATA_WIDTH-1:0] right_o,
    output logic                  right_valid_o,
    output logic                  right_first_o,
    output logic                  right_last_o,
    output logic                  right_signed_o,
    output logic [ACC_WIDTH-1:0]  res_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic                  res_ovf_o,
    output logic                  res_lost_o
);

    localparam int PW = 2*DATA_WIDTH;

    // Overflow of base + ext, interpreted in the beat's mode.
    function automatic logic beat_ovf(input logic sgn,
                                      input logic [ACC_WIDTH-1:0] base,
                                      input logic [ACC_WIDTH-1:0] ext,
                                      input logic [ACC_WIDTH:0]   sum);
        if (sgn)
            return (base[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
        else
            return sum[ACC_WIDTH];
    endfunction

`ifdef PE_MAC_SATURATE_EN
    // Clamp value for an overflowing beat. A signed overflow can only occur when
    // both addends share a sign, so the addend sign picks the rail.
    function automatic logic [ACC_WIDTH-1:0] sat_clamp(input logic sgn, input logic neg);
        if (!sgn)
            return '1;
        else if (neg)
            return {1'b1, {(ACC_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(ACC_WIDTH-1){1'b1}}};
    endfunction
`endif

    logic                  mac_beat;
    logic signed [PW-1:0]  up_ext;
    logic signed [PW-1:0]  left_ext;
    logic signed [PW-1:0]  prod_nxt;

    logic signed [PW-1:0]  prod_p1;
    logic                  vld_p1;
    logic                  first_p1;
    logic                  last_p1;
    logic                  sgn_p1;

    // The accumulator holds raw bits; each beat reinterprets it in its own mode.
    logic [ACC_WIDTH-1:0]  acc_p2;
    logic                  tile_ovf_p2;

    logic [ACC_WIDTH-1:0]  ext;
    logic [ACC_WIDTH-1:0]  base;
    logic [ACC_WIDTH:0]    sum;
    logic                  ovf;
    logic [ACC_WIDTH-1:0]  acc_nxt;
    logic                  tile_ovf_nxt;
    logic                  load;

    assign mac_beat = up_valid_i & left_valid_i;

    // Extending both operands to PW bits makes the low PW bits of one multiply
    // correct for both the signed and the unsigned interpretation.
    always_comb begin
        up_ext   = signed_i ? {{DATA_WIDTH{up_i[DATA_WIDTH-1]}}, up_i}
                            : {{DATA_WIDTH{1'b0}}, up_i};
        left_ext = signed_i ? {{DATA_WIDTH{left_i[DATA_WIDTH-1]}}, left_i}
                            : {{DATA_WIDTH{1'b0}}, left_i};
        prod_nxt = up_ext * left_ext;
    end

    always_comb begin
        ext          = sgn_p1 ? ACC_WIDTH'(prod_p1) : ACC_WIDTH'($unsigned(prod_p1));
        base         = first_p1 ? '0 : acc_p2;
        sum          = {1'b0, base} + {1'b0, ext};
        ovf          = beat_ovf(sgn_p1, base, ext, sum);
`ifdef PE_MAC_SATURATE_EN
        acc_nxt      = ovf ? sat_clamp(sgn_p1, ext[ACC_WIDTH-1]) : sum[ACC_WIDTH-1:0];
`else
        acc_nxt      = sum[ACC_WIDTH-1:0];
`endif
        tile_ovf_nxt = (first_p1 ? 1'b0 : tile_ovf_p2) | ovf;
        load         = vld_p1 & last_p1;
    end

    // ---- forwarding and stage 1: operand registers and product ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            down_o         <= '0;
            down_valid_o   <= 1'b0;
            right_o        <= '0;
            right_valid_o  <= 1'b0;
            right_first_o  <= 1'b0;
            right_last_o   <= 1'b0;
            right_signed_o <= 1'b0;
            prod_p1        <= '0;
            vld_p1         <= 1'b0;
            first_p1       <= 1'b0;
            last_p1        <= 1'b0;
            sgn_p1         <= 1'b0;
        end else begin
            down_o         <= up_i;
            down_valid_o   <= up_valid_i;
            right_o        <= left_i;
            right_valid_o  <= left_valid_i;
            right_first_o  <= first_i;
            right_last_o   <= last_i;
            right_signed_o <= signed_i;
            prod_p1        <= prod_nxt;
            vld_p1         <= mac_beat;
            first_p1       <= mac_beat & first_i;
            last_p1        <= mac_beat & last_i;
            sgn_p1         <= signed_i;
        end
    end

    // ---- stage 2: accumulate, tile overflow, result handshake ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_p2      <= '0;
            tile_ovf_p2 <= 1'b0;
            res_o       <= '0;
            res_ovf_o   <= 1'b0;
            res_valid_o <= 1'b0;
            res_lost_o  <= 1'b0;
        end else begin
            if (vld_p1) begin
                acc_p2      <= acc_nxt;
                tile_ovf_p2 <= tile_ovf_nxt;
            end
            if (load) begin
                res_o       <= acc_nxt;
                res_ovf_o   <= tile_ovf_nxt;
                res_valid_o <= 1'b1;
                // Replacing a result nobody took this cycle loses it.
                if (res_valid_o && !res_ready_i)
                    res_lost_o <= 1'b1;
            end else if (res_valid_o && res_ready_i) begin
                res_valid_o <= 1'b0;
            end
        end
    end

endmodule
